func2_cursor_ctrl: RTL and testbench
====================================

// Module: func2_cursor_ctrl
// PURPOSE
//   Consumer of the function-2 instruction word {East,West,North,South} and func_index.
//   Synchronises and debounces the four direction bits and emits single-step moves
//   with hold-to-auto-repeat. Maintains a wrap-around cursor position on a COLS x ROWS
//   grid for the VGA function-2 renderer. Origin (0,0) is top-left.
// PARAMETERS
//   COLS            16      grid columns; cursor_x range 0..COLS-1
//   ROWS            12      grid rows; cursor_y range 0..ROWS-1
//   X_W             4       cursor_x width; 2**X_W >= COLS
//   Y_W             4       cursor_y width; 2**Y_W >= ROWS
//   DEBOUNCE_CYCLES 500000  consecutive stable cycles before a bit change is accepted
//   REPEAT_DELAY    25000000 cycles a direction is held before auto-repeat starts
//   REPEAT_PERIOD   5000000 cycles between auto-repeat steps
// PORTS
//   sysclk            in   1    system clock, rising edge
//   reset_n           in   1    asynchronous active-low reset
//   func_index        in   2    active function; block responds only when == 2'd1
//   func2_instruction in   4    {East,West,North,South}, raw, asynchronous to sysclk
//   cursor_x          out  X_W  current column
//   cursor_y          out  Y_W  current row
//   move_pulse        out  1    one-cycle strobe, high in the cycle the cursor takes a new value
//   dir_held          out  4    debounced direction vector {E,W,N,S}
// BEHAVIOUR
//   Reset (async, reset_n=0): cursor_x=0, cursor_y=0, move_pulse=0, dir_held=0,
//     synchroniser/debounce/repeat counters cleared, FSM=IDLE. Takes effect immediately
//     mid-operation. No step is generated on release of reset, even if a button is held.
//   Gating: when func_index != 1 the raw vector is forced to 4'b0000 before the
//     synchroniser (treated as released). Cursor holds its value across function switches.
//   Synchroniser: 2-flop per bit.
//   Debounce: per bit, a counter counts up while the synced bit differs from dir_held.
//     dir_held is updated when the count reaches DEBOUNCE_CYCLES, and the counter is cleared.
//     Any return to equality clears the counter.
//   Direction resolve: dx = E&~W ? +1 : W&~E ? -1 : 0; dy = S&~N ? +1 : N&~S ? -1 : 0.
//     E+W or N+S cancel on that axis. Diagonals are allowed. If the resolved vector is
//     (0,0), no step occurs.
//   Step: x' = (x+dx) mod COLS, y' = (y+dy) mod ROWS. Wrap: x=COLS-1,+1 -> 0; x=0,-1 -> COLS-1;
//     same for y. Arithmetic is done one bit wider to avoid overflow.
//     The registered cursor and move_pulse update on the same edge.
//   FSM on dir_held:
//     IDLE:   dir_held != 0 -> step, cnt=0, go DELAY.
//     DELAY:  dir_held==0 -> IDLE. dir_held changed to another nonzero value -> step,
//             cnt=0, stay DELAY. cnt==REPEAT_DELAY-1 -> step, cnt=0, go REPEAT. Else cnt++.
//     REPEAT: dir_held==0 -> IDLE. Changed nonzero -> step, cnt=0, go DELAY.
//             cnt==REPEAT_PERIOD-1 -> step, cnt=0. Else cnt++.
//   Latency: raw edge -> move_pulse = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//     A step that resolves to (0,0) (e.g. E+W only) still advances the FSM but leaves the
//     cursor unchanged and move_pulse=0.
//   At most one step per cycle. move_pulse is never high for two consecutive cycles
//     unless REPEAT_PERIOD==1.
// TESTING  (COLS=8, ROWS=6, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//   1. func_index=1, East pulse held 20 cycles from (0,0) -> one move_pulse 7 cycles after
//      the edge, cursor (1,0), then repeats every 3 cycles after 10 more cycles.
//   2. Bounce: East toggles every 2 cycles for 30 cycles, then low -> no move_pulse,
//      cursor unchanged.
//   3. Wrap: cursor (7,5), tap East+South -> (0,0); tap West+North -> (7,5).
//   4. Cancel: hold East+West -> cursor_x unchanged, move_pulse never asserts.
//      Add North -> y decrements (wrap 0->5).
//   5. func_index=0 with South held -> no move. Switch to 1 while still held ->
//      a step 7 cycles later. Switch back to 2 -> dir_held clears after debounce,
//      cursor holds.
//   6. Assert reset_n=0 mid auto-repeat -> outputs 0 asynchronously. Release with East
//      still held -> first step only after the full debounce latency.

Source files
------------

// File: rtl/func2_cursor_if.sv
// Function-2 cursor bus: instruction word and active-function select in,
// cursor position, move strobe and debounced direction vector out.
interface func2_cursor_if #(
  parameter int unsigned X_W = 4,
  parameter int unsigned Y_W = 4
);
  logic [1:0]     func_index;
  logic [3:0]     func2_instruction;
  logic [X_W-1:0] cursor_x;
  logic [Y_W-1:0] cursor_y;
  logic           move_pulse;
  logic [3:0]     dir_held;

  modport master (
    output func_index,
    output func2_instruction,
    input  cursor_x,
    input  cursor_y,
    input  move_pulse,
    input  dir_held
  );

  modport slave (
    input  func_index,
    input  func2_instruction,
    output cursor_x,
    output cursor_y,
    output move_pulse,
    output dir_held
  );
endinterface

// File: rtl/func2_cursor_ctrl.sv
// Debounced {E,W,N,S} direction input driving a wrap-around grid cursor with
// single-step moves and hold-to-auto-repeat.
module func2_cursor_ctrl #(
  parameter int unsigned COLS            = 16,
  parameter int unsigned ROWS            = 12,
  parameter int unsigned X_W             = 4,
  parameter int unsigned Y_W             = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic         sysclk,
  input  logic         reset_n,
  func2_cursor_if.slave bus
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  logic [3:0]     raw_gated;
  logic [3:0]     sync1_q, sync2_q;
  logic [3:0]     held_q, held_d, held_prev_q;
  logic [DbW-1:0] db_cnt_q [4];
  logic [DbW-1:0] db_cnt_d [4];

  state_e          state_q, state_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            step;

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           move_pulse_q, move_pulse_d;

  // Other functions look like all buttons released to the synchroniser.
  assign raw_gated = (bus.func_index == 2'd1) ? bus.func2_instruction : 4'b0000;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      held_d[i]   = held_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != held_q[i]) begin
        if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          held_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    step      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (held_q != 4'b0000) begin
          step      = 1'b1;
          rep_cnt_d = '0;
          state_d   = StDelay;
        end
      end
      StDelay: begin
        if (held_q == 4'b0000) begin
          state_d = StIdle;
        end else if (held_q != held_prev_q) begin
          step      = 1'b1;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == RepW'(REPEAT_DELAY - 1)) begin
          step      = 1'b1;
          rep_cnt_d = '0;
          state_d   = StRepeat;
        end else begin
          rep_cnt_d = rep_cnt_q + RepW'(1);
        end
      end
      StRepeat: begin
        if (held_q == 4'b0000) begin
          state_d = StIdle;
        end else if (held_q != held_prev_q) begin
          step      = 1'b1;
          rep_cnt_d = '0;
          state_d   = StDelay;
        end else if (rep_cnt_q == RepW'(REPEAT_PERIOD - 1)) begin
          step      = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RepW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic           dx_pos, dx_neg, dy_pos, dy_neg;
  logic [X_W:0]   x_inc;
  logic [Y_W:0]   y_inc;
  logic [X_W-1:0] x_step;
  logic [Y_W-1:0] y_step;

  // held bit order is {E, W, N, S}; opposing pairs cancel on their axis.
  assign dx_pos = held_q[3] & ~held_q[2];
  assign dx_neg = held_q[2] & ~held_q[3];
  assign dy_pos = held_q[0] & ~held_q[1];
  assign dy_neg = held_q[1] & ~held_q[0];

  assign x_inc = {1'b0, x_q} + (X_W + 1)'(1);
  assign y_inc = {1'b0, y_q} + (Y_W + 1)'(1);

  always_comb begin
    x_step = x_q;
    if (dx_pos) begin
      x_step = (x_inc == (X_W + 1)'(COLS)) ? '0 : x_inc[X_W-1:0];
    end else if (dx_neg) begin
      x_step = (x_q == '0) ? X_W'(COLS - 1) : x_q - X_W'(1);
    end
    y_step = y_q;
    if (dy_pos) begin
      y_step = (y_inc == (Y_W + 1)'(ROWS)) ? '0 : y_inc[Y_W-1:0];
    end else if (dy_neg) begin
      y_step = (y_q == '0) ? Y_W'(ROWS - 1) : y_q - Y_W'(1);
    end
  end

  always_comb begin
    move_pulse_d = step & (dx_pos | dx_neg | dy_pos | dy_neg);
    x_d          = move_pulse_d ? x_step : x_q;
    y_d          = move_pulse_d ? y_step : y_q;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      held_q       <= '0;
      held_prev_q  <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      state_q      <= StIdle;
      rep_cnt_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      move_pulse_q <= 1'b0;
    end else begin
      sync1_q      <= raw_gated;
      sync2_q      <= sync1_q;
      held_q       <= held_d;
      held_prev_q  <= held_q;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q      <= state_d;
      rep_cnt_q    <= rep_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      move_pulse_q <= move_pulse_d;
    end
  end

  assign bus.cursor_x   = x_q;
  assign bus.cursor_y   = y_q;
  assign bus.move_pulse = move_pulse_q;
  assign bus.dir_held   = held_q;

endmodule

// File: tb/tb_func2_cursor_ctrl.sv
// Scoreboarded bench for func2_cursor_ctrl: expected moves (cycle and position)
// are queued at stimulus time and matched against every move_pulse.
module tb_func2_cursor_ctrl;

  localparam int unsigned Cols      = 8;
  localparam int unsigned Rows      = 6;
  localparam int unsigned XW        = 3;
  localparam int unsigned YW        = 3;
  localparam int unsigned Deb       = 4;
  localparam int unsigned RepDelay  = 10;
  localparam int unsigned RepPeriod = 3;
  localparam int          Lat       = 2 + Deb + 1;

  localparam logic [3:0] DirE = 4'b1000;
  localparam logic [3:0] DirW = 4'b0100;
  localparam logic [3:0] DirN = 4'b0010;
  localparam logic [3:0] DirS = 4'b0001;

  logic sysclk  = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;

  func2_cursor_if #(.X_W(XW), .Y_W(YW)) bus ();

  func2_cursor_ctrl #(
    .COLS           (Cols),
    .ROWS           (Rows),
    .X_W            (XW),
    .Y_W            (YW),
    .DEBOUNCE_CYCLES(Deb),
    .REPEAT_DELAY   (RepDelay),
    .REPEAT_PERIOD  (RepPeriod)
  ) dut (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int x;
    int y;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mx       = 0;
  int   my       = 0;

  // Every move_pulse must match the next queued expectation.
  always @(negedge sysclk) begin
    if (bus.move_pulse === 1'b1) begin
      exp_t e;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cycle %0d pos (%0d,%0d), required no pulse",
                 cyc, bus.cursor_x, bus.cursor_y);
      end else begin
        e = sb_q.pop_front();
        if (cyc != e.t || bus.cursor_x !== XW'(e.x) || bus.cursor_y !== YW'(e.y)) begin
          n_fail++;
          $display("FAIL pulse_check: got cycle %0d pos (%0d,%0d), required cycle %0d pos (%0d,%0d)",
                   cyc, bus.cursor_x, bus.cursor_y, e.t, e.x, e.y);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  // Applies one step to the bench's cursor model; returns 1 if the cursor moves.
  function automatic bit model_step(input logic [3:0] d);
    bit ex, wx, nx, sx;
    int ox, oy;
    ex = d[3]; wx = d[2]; nx = d[1]; sx = d[0];
    ox = mx; oy = my;
    if (ex && !wx) mx = (mx + 1) % Cols;
    else if (wx && !ex) mx = (mx + Cols - 1) % Cols;
    if (sx && !nx) my = (my + 1) % Rows;
    else if (nx && !sx) my = (my + Rows - 1) % Rows;
    return (ox != mx) || (oy != my) || ((ex != wx) || (nx != sx));
  endfunction

  // Raw vector d asserted at cycle c0 for len cycles: first step at +Lat, repeat after
  // RepDelay, then every RepPeriod while the debounced vector is still held.
  function automatic void push_hold(input int c0, input logic [3:0] d, input int len,
                                    input int cutoff);
    int t;
    int k;
    t = c0 + Lat;
    k = 0;
    while (t <= c0 + len + Deb + 2 && t - c0 <= cutoff) begin
      if (model_step(d)) sb_q.push_back('{t, mx, my});
      t += (k == 0) ? RepDelay : RepPeriod;
      k++;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic hold_dir(input logic [3:0] d, input int len);
    int c0;
    tick(1);
    c0 = cyc;
    push_hold(c0, d, len, 1000);
    bus.func2_instruction = d;
    tick(len);
    bus.func2_instruction = 4'b0000;
    tick(Deb + Lat + 4);
  endtask

  task automatic check_pos(input string name);
    n_checks++;
    if (bus.cursor_x !== XW'(mx) || bus.cursor_y !== YW'(my)) begin
      n_fail++;
      $display("FAIL %s: got (%0d,%0d), required (%0d,%0d)", name,
               bus.cursor_x, bus.cursor_y, mx, my);
    end
  endtask

  task automatic test_reset();
    bus.func_index        = 2'd1;
    bus.func2_instruction = 4'b0000;
    reset_n               = 1'b0;
    tick(3);
    n_checks += 4;
    if (bus.cursor_x !== 3'd0) begin
      n_fail++; $display("FAIL reset_x: got %0d, required 0", bus.cursor_x);
    end
    if (bus.cursor_y !== 3'd0) begin
      n_fail++; $display("FAIL reset_y: got %0d, required 0", bus.cursor_y);
    end
    if (bus.move_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulse: got %b, required 0", bus.move_pulse);
    end
    if (bus.dir_held !== 4'b0000) begin
      n_fail++; $display("FAIL reset_dir: got %b, required 0000", bus.dir_held);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_hold_repeat();
    int c0;
    tick(1);
    c0 = cyc;
    push_hold(c0, DirE, 20, 1000);
    bus.func2_instruction = DirE;
    tick(8);
    n_checks++;
    if (bus.dir_held !== DirE) begin
      n_fail++; $display("FAIL hold_dir_held: got %b, required %b", bus.dir_held, DirE);
    end
    tick(12);
    bus.func2_instruction = 4'b0000;
    tick(15);
    check_pos("hold_final_pos");
  endtask

  task automatic test_bounce();
    logic [3:0] v;
    tick(1);
    v = DirE;
    for (int i = 0; i < 15; i++) begin
      bus.func2_instruction = v;
      tick(2);
      v = v ^ DirE;
      n_checks++;
      if (bus.dir_held !== 4'b0000) begin
        n_fail++; $display("FAIL bounce_dir: got %b, required 0000", bus.dir_held);
      end
    end
    bus.func2_instruction = 4'b0000;
    tick(15);
    check_pos("bounce_pos");
  endtask

  task automatic test_wrap();
    while (mx != Cols - 1) hold_dir(DirE, 5);
    while (my != Rows - 1) hold_dir(DirN, 5);
    check_pos("wrap_start");
    hold_dir(DirE | DirS, 5);
    n_checks++;
    if (bus.cursor_x !== 3'd0 || bus.cursor_y !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_fwd: got (%0d,%0d), required (0,0)", bus.cursor_x, bus.cursor_y);
    end
    hold_dir(DirW | DirN, 5);
    n_checks++;
    if (bus.cursor_x !== 3'd7 || bus.cursor_y !== 3'd5) begin
      n_fail++;
      $display("FAIL wrap_back: got (%0d,%0d), required (7,5)", bus.cursor_x, bus.cursor_y);
    end
  endtask

  task automatic test_cancel();
    int c0;
    hold_dir(DirS, 5);
    tick(1);
    c0 = cyc;
    bus.func2_instruction = DirE | DirW;
    tick(8);
    n_checks++;
    if (bus.dir_held !== 4'b1100) begin
      n_fail++; $display("FAIL cancel_dir: got %b, required 1100", bus.dir_held);
    end
    check_pos("cancel_x_hold");
    if (model_step(DirE | DirW | DirN)) sb_q.push_back('{c0 + 15, mx, my});
    bus.func2_instruction = DirE | DirW | DirN;
    tick(8);
    bus.func2_instruction = 4'b0000;
    tick(16);
    check_pos("cancel_north");
  endtask

  task automatic test_func_gate();
    int c1;
    tick(1);
    bus.func_index        = 2'd0;
    bus.func2_instruction = DirS;
    tick(15);
    n_checks++;
    if (bus.dir_held !== 4'b0000) begin
      n_fail++; $display("FAIL gate_dir_off: got %b, required 0000", bus.dir_held);
    end
    check_pos("gate_no_move");
    bus.func_index = 2'd1;
    c1 = cyc;
    if (model_step(DirS)) sb_q.push_back('{c1 + Lat, mx, my});
    tick(10);
    n_checks++;
    if (bus.dir_held !== DirS) begin
      n_fail++; $display("FAIL gate_dir_on: got %b, required %b", bus.dir_held, DirS);
    end
    bus.func_index = 2'd2;
    tick(6);
    n_checks++;
    if (bus.dir_held !== 4'b0000) begin
      n_fail++; $display("FAIL gate_dir_release: got %b, required 0000", bus.dir_held);
    end
    tick(10);
    check_pos("gate_hold_pos");
    bus.func2_instruction = 4'b0000;
    bus.func_index        = 2'd1;
    tick(15);
  endtask

  task automatic test_reset_mid();
    int c0;
    int c2;
    tick(1);
    c0 = cyc;
    push_hold(c0, DirE, 1000, 19);
    bus.func2_instruction = DirE;
    tick(20);
    #2;
    n_checks++;
    if (bus.move_pulse !== 1'b1) begin
      n_fail++; $display("FAIL mid_repeat_pulse: got %b, required 1", bus.move_pulse);
    end
    reset_n = 1'b0;
    #1;
    mx = 0;
    my = 0;
    n_checks += 2;
    if (bus.cursor_x !== 3'd0 || bus.cursor_y !== 3'd0 || bus.move_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_out: got (%0d,%0d) pulse %b, required (0,0) pulse 0",
               bus.cursor_x, bus.cursor_y, bus.move_pulse);
    end
    if (bus.dir_held !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset_dir: got %b, required 0000", bus.dir_held);
    end
    tick(3);
    reset_n = 1'b1;
    c2 = cyc;
    if (model_step(DirE)) sb_q.push_back('{c2 + Lat, mx, my});
    tick(8);
    bus.func2_instruction = 4'b0000;
    tick(15);
    check_pos("reset_release_pos");
  endtask

  initial begin
    bus.func_index        = 2'd1;
    bus.func2_instruction = 4'b0000;
    test_reset();
    test_hold_repeat();
    test_bounce();
    test_wrap();
    test_cancel();
    test_func_gate();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: got %0d unmatched expectations, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
